// File: rtl/fe_pkg.sv
// fe_pkg: definitions shared by the front-end blocks (fetch_queue, fetch_unit,
// decode_unit).
//   fe_byte_t      - one instruction byte
//   FE_WB(word_w)  - number of bytes in a fetch word of word_w bits
//   clog2(value)   - ceiling log2, usable in parameter/port expressions
package fe_pkg;

  typedef logic [7:0] fe_byte_t;

  function automatic int FE_WB(input int word_w);
    return word_w / 8;
  endfunction

  // Smallest r with 2**r >= value; clog2(1) = 0.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/byte_ring.sv
// byte_ring: byte-addressed circular store used by the prefetch queue.
//   clk      - clock
//   wr_en    - write strobe for this cycle
//   wr_ptr   - ring index receiving lane 0 of wr_data
//   wr_data  - WB byte lanes, lane j goes to ring[wr_ptr + j]
//   wr_mask  - per-lane write enable
//   rd_ptr   - ring index presented as byte 0 of rd_data
//   rd_data  - OUT_BYTES bytes starting at rd_ptr, wrapping around the ring
// The ring holds no pointers or counts; those live in the owner.
module byte_ring
  import fe_pkg::*;
#(
  parameter int WB        = 4,
  parameter int DEPTH     = 4,
  parameter int OUT_BYTES = 4,
  parameter int PW        = 4
) (
  input  logic                   clk,
  input  logic                   wr_en,
  input  logic [PW-1:0]          wr_ptr,
  input  logic [WB*8-1:0]        wr_data,
  input  logic [WB-1:0]          wr_mask,
  input  logic [PW-1:0]          rd_ptr,
  output logic [OUT_BYTES*8-1:0] rd_data
);

  localparam int RING = WB * DEPTH;

  fe_byte_t mem [RING];

  // Lanes are written at consecutive ring slots starting at wr_ptr, which is
  // not necessarily word aligned after a redirect into the middle of a word.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int j = 0; j < WB; j++) begin
        if (wr_mask[j]) begin
          mem[wr_ptr + PW'(j)] <= wr_data[j*8 +: 8];
        end
      end
    end
  end

  // Rotating read: the PW-bit index sum wraps around the ring by itself.
  for (genvar gi = 0; gi < OUT_BYTES; gi++) begin : g_rd
    assign rd_data[gi*8 +: 8] = mem[rd_ptr + PW'(gi)];
  end

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: byte-granular instruction prefetch queue.
// Fetches aligned words from instruction memory into a byte ring and presents
// the decoder with a window of up to OUT_BYTES bytes starting at id_pc.
//   clk          - clock
//   a_rst        - synchronous reset, active low
//   i_mem_pc     - word-aligned fetch address
//   i_mem_req    - fetch request (room for a whole word)
//   i_mem_opcode - fetched word, byte 0 in bits [7:0] at the lowest address
//   i_mem_rdy    - memory word valid; accepted when i_mem_req & i_mem_rdy
//   ex_pc_w      - redirect strobe (flush and restart at ex_pc)
//   ex_pc        - redirect byte address
//   id_window    - decoder window, byte k at id_pc+k, zero above id_valid
//   id_valid     - number of valid window bytes
//   id_pc        - address of window byte 0
//   id_consume   - bytes retired by the decoder this cycle
module fetch_queue
  import fe_pkg::*;
#(
  parameter int              WORD_W    = 32,
  parameter int              DEPTH     = 4,
  parameter int              OUT_BYTES = 4,
  parameter int              PC_W      = 16,
  parameter logic [PC_W-1:0] RESET_PC  = '0
) (
  input  logic                             clk,
  input  logic                             a_rst,
  output logic [PC_W-1:0]                  i_mem_pc,
  output logic                             i_mem_req,
  input  logic [WORD_W-1:0]                i_mem_opcode,
  input  logic                             i_mem_rdy,
  input  logic                             ex_pc_w,
  input  logic [PC_W-1:0]                  ex_pc,
  output logic [OUT_BYTES*8-1:0]           id_window,
  output logic [clog2(OUT_BYTES+1)-1:0]    id_valid,
  output logic [PC_W-1:0]                  id_pc,
  input  logic [clog2(OUT_BYTES+1)-1:0]    id_consume
);

  localparam int WB   = FE_WB(WORD_W);
  localparam int RING = WB * DEPTH;
  localparam int PW   = clog2(RING);
  localparam int CW   = PW + 1;
  localparam int VW   = clog2(OUT_BYTES + 1);

  localparam logic [PC_W-1:0] WORD_MASK  = PC_W'(WB - 1);
  localparam logic [CW-1:0]   REQ_LIMIT  = CW'(RING - WB);
  localparam logic [CW-1:0]   RESET_SKIP = CW'(RESET_PC & WORD_MASK);

  // Queue state
  logic [PW-1:0]   rd_reg, rd_next;
  logic [PW-1:0]   wr_reg, wr_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic [CW-1:0]   skip_reg, skip_next;
  logic [PC_W-1:0] mem_pc_reg, mem_pc_next;
  logic [PC_W-1:0] id_pc_reg, id_pc_next;

  // Datapath
  logic                   accept;
  logic                   wr_en;
  logic [CW-1:0]          fill_bytes;
  logic [WORD_W-1:0]      word_shifted;
  logic [WB-1:0]          wr_mask;
  logic [VW-1:0]          valid;
  logic [VW-1:0]          consume_eff;
  logic [OUT_BYTES*8-1:0] ring_window;

  assign i_mem_req = a_rst & (cnt_reg <= REQ_LIMIT);
  assign accept    = i_mem_req & i_mem_rdy;
  // A redirect in the same cycle discards the word, so nothing is written.
  assign wr_en     = accept & ~ex_pc_w;

  // The first word after a redirect loses its leading skip bytes; shifting
  // them out lets the ring always write from lane 0 at wr.
  assign fill_bytes   = CW'(WB) - skip_reg;
  assign word_shifted = i_mem_opcode >> {skip_reg, 3'b000};

  for (genvar gi = 0; gi < WB; gi++) begin : g_mask
    assign wr_mask[gi] = (CW'(gi) < fill_bytes);
  end

  assign valid       = (cnt_reg < CW'(OUT_BYTES)) ? VW'(cnt_reg) : VW'(OUT_BYTES);
  // An over-large consume is clamped so cnt can never underflow.
  assign consume_eff = (id_consume > valid) ? valid : id_consume;

  byte_ring #(
    .WB        (WB),
    .DEPTH     (DEPTH),
    .OUT_BYTES (OUT_BYTES),
    .PW        (PW)
  ) u_ring (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_ptr  (wr_reg),
    .wr_data (word_shifted),
    .wr_mask (wr_mask),
    .rd_ptr  (rd_reg),
    .rd_data (ring_window)
  );

  // Stale ring contents above the valid count are hidden from the decoder.
  for (genvar gi = 0; gi < OUT_BYTES; gi++) begin : g_win
    assign id_window[gi*8 +: 8] = (VW'(gi) < valid) ? ring_window[gi*8 +: 8] : 8'h00;
  end

  assign id_valid = valid;
  assign id_pc    = id_pc_reg;
  assign i_mem_pc = mem_pc_reg;

  always_comb begin
    rd_next     = rd_reg;
    wr_next     = wr_reg;
    cnt_next    = cnt_reg;
    skip_next   = skip_reg;
    mem_pc_next = mem_pc_reg;
    id_pc_next  = id_pc_reg;
    if (ex_pc_w) begin
      // Flush: both the accepted word and the consume are dropped.
      rd_next     = '0;
      wr_next     = '0;
      cnt_next    = '0;
      skip_next   = CW'(ex_pc & WORD_MASK);
      mem_pc_next = ex_pc & ~WORD_MASK;
      id_pc_next  = ex_pc;
    end else begin
      rd_next    = rd_reg + PW'(consume_eff);
      id_pc_next = id_pc_reg + PC_W'(consume_eff);
      cnt_next   = cnt_reg + (accept ? fill_bytes : '0) - CW'(consume_eff);
      if (accept) begin
        wr_next     = wr_reg + PW'(fill_bytes);
        mem_pc_next = mem_pc_reg + PC_W'(WB);
        skip_next   = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!a_rst) begin
      rd_reg     <= '0;
      wr_reg     <= '0;
      cnt_reg    <= '0;
      skip_reg   <= RESET_SKIP;
      mem_pc_reg <= RESET_PC & ~WORD_MASK;
      id_pc_reg  <= RESET_PC;
    end else begin
      rd_reg     <= rd_next;
      wr_reg     <= wr_next;
      cnt_reg    <= cnt_next;
      skip_reg   <= skip_next;
      mem_pc_reg <= mem_pc_next;
      id_pc_reg  <= id_pc_next;
    end
  end

endmodule
